// File: rtl/alu_exec_unit.sv
// Execute unit for the 3-bit ALU opcode. Latency is 1 cycle, or shamt+1 for serial shifts (1 with ALU_FAST_SHIFT_EN).
// Backpressure: accepts only in IDLE; result and zero hold in DONE until out_ready.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALU_opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  logic [SHW-1:0]   cnt;
  logic             shift_left;
  logic             is_shift;
  logic [WIDTH-1:0] shift_val;

  assign is_shift  = (ALU_opcode == OP_SLL) || (ALU_opcode == OP_SRL);
  assign shift_val = shift_left ? {result[WIDTH-2:0], 1'b0} : {1'b0, result[WIDTH-1:1]};
`endif

  state_t           state, state_nxt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] load_val;

  assign shamt = B[SHW-1:0];

  // Value written to result on the acceptance edge; serial shifts start from A.
  always_comb begin
    load_val = '0;
    case (ALU_opcode)
      OP_ADD:  load_val = A + B;
      OP_SUB:  load_val = A - B;
      OP_AND:  load_val = A & B;
      OP_OR:   load_val = A | B;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  load_val = A << shamt;
      OP_SRL:  load_val = A >> shamt;
`else
      OP_SLL:  load_val = A;
      OP_SRL:  load_val = A;
`endif
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
          state_nxt = DONE;
`else
          state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
`endif
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      SHIFT:   if (cnt == SHW'(1)) state_nxt = DONE;
`endif
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result     <= '0;
      zero       <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
      cnt        <= '0;
      shift_left <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            result     <= load_val;
            zero       <= (load_val == '0);
`ifndef ALU_FAST_SHIFT_EN
            cnt        <= shamt;
            shift_left <= (ALU_opcode == OP_SLL);
`endif
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          result <= shift_val;
          zero   <= (shift_val == '0);
          cnt    <= cnt - SHW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
